// File: rtl/cpu_timing_pkg.sv
// cpu_timing_pkg: shared encodings for the machine-cycle timing generator.
//   phase_t      : T-phase encoding (PH_T1/PH_T2/PH_T3)
//   state_t      : sequencer state (ST_HALT/ST_RUN)
//   W_B1..W_B3   : one-hot beat values {W3,W2,W1}
//   phase_onehot : phase -> {T3,T2,T1} pulse vector
package cpu_timing_pkg;

    typedef enum logic [1:0] {
        PH_T1 = 2'd0,
        PH_T2 = 2'd1,
        PH_T3 = 2'd2
    } phase_t;

    typedef enum logic {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [2:0] W_B1 = 3'b001;
    localparam logic [2:0] W_B2 = 3'b010;
    localparam logic [2:0] W_B3 = 3'b100;

    function automatic logic [2:0] phase_onehot(input phase_t ph);
        case (ph)
            PH_T1:   phase_onehot = 3'b001;
            PH_T2:   phase_onehot = 3'b010;
            default: phase_onehot = 3'b100;
        endcase
    endfunction

endpackage

// File: rtl/qd_sync.sv
// qd_sync: QD_SYNC-stage synchroniser plus rising-edge detector for the
// asynchronous QD start button.
//   clk   : master clock
//   clr   : asynchronous active-high reset
//   qd    : raw pushbutton level
//   start : one-CLK pulse per synchronised rising edge of qd
module qd_sync #(
    parameter int unsigned QD_SYNC = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic qd,
    output logic start
);

    logic [QD_SYNC-1:0] sync;
    logic               prev;

    // The chain and edge history are preset to 1 so that a QD level already
    // high when CLR is released never looks like a rising edge; a low level
    // simply shifts in, and only a later 0->1 transition produces a pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync  <= '1;
            prev  <= 1'b1;
            start <= 1'b0;
        end else begin
            sync  <= {sync[QD_SYNC-2:0], qd};
            prev  <= sync[QD_SYNC-1];
            start <= sync[QD_SYNC-1] & ~prev;
        end
    end

endmodule

// File: rtl/beat_timing_gen.sv
// beat_timing_gen: machine-cycle timing generator for the hardwired
// controller. Produces the rotating T1/T2/T3 phase pulses and the one-hot
// beat vector W[3:1]; each phase lasts T_DIV CLKs. The controller's SHORT,
// LONG and STOP requests are sampled on the last CLK of T3 only.
//   CLK     : master clock          CLR   : async active-high reset
//   QD      : async start button    SHORT : end cycle after W1
//   LONG    : extend cycle to W3    STOP  : halt at end of machine cycle
//   T1..T3  : phase pulses          W     : one-hot beat, 000 when halted
//   RUNNING : sequencer running     CYC_END : last CLK of a machine cycle
// Optional build macro STEP_MODE_EN adds input STEP: halt after every beat,
// holding W, and resume at the retained next beat on the next QD edge.
module beat_timing_gen
    import cpu_timing_pkg::*;
#(
    parameter int unsigned T_DIV   = 1,
    parameter int unsigned QD_SYNC = 2
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       QD,
    input  logic       SHORT,
    input  logic       LONG,
    input  logic       STOP,
`ifdef STEP_MODE_EN
    input  logic       STEP,
`endif
    output logic       T1,
    output logic       T2,
    output logic       T3,
    output logic [2:0] W,
    output logic       RUNNING,
    output logic       CYC_END
);

    localparam int unsigned    DW       = (T_DIV > 1) ? $clog2(T_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(T_DIV - 1);

    state_t        state;
    phase_t        phase;
    logic [DW-1:0] div;
    logic          start;
    logic          sample;
    logic          cycle_end;
    logic [2:0]    beat_next;

`ifdef STEP_MODE_EN
    logic [2:0]    resume_beat;
`endif

    qd_sync #(
        .QD_SYNC (QD_SYNC)
    ) u_qd_sync (
        .clk   (CLK),
        .clr   (CLR),
        .qd    (QD),
        .start (start)
    );

    // Last CLK of T3: the only point where the beat may change.
    assign sample = (state == ST_RUN) && (phase == PH_T3) && (div == DIV_LAST);

    always_comb begin
        cycle_end = 1'b0;
        beat_next = W_B1;
        case (W)
            W_B1:    if (SHORT) cycle_end = 1'b1; else beat_next = W_B2;
            W_B2:    if (LONG)  beat_next = W_B3; else cycle_end = 1'b1;
            default: cycle_end = 1'b1;
        endcase
    end

    // Decoded rather than registered: whether this CLK ends the cycle depends
    // on SHORT/LONG sampled on this very CLK, so a register could only report
    // it one CLK late.
    assign CYC_END = sample && cycle_end;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state        <= ST_HALT;
            phase        <= PH_T1;
            div          <= '0;
            W            <= '0;
            {T3, T2, T1} <= '0;
            RUNNING      <= 1'b0;
`ifdef STEP_MODE_EN
            resume_beat  <= W_B1;
`endif
        end else begin
            case (state)
                ST_HALT: begin
                    if (start) begin
                        state        <= ST_RUN;
                        phase        <= PH_T1;
                        div          <= '0;
                        {T3, T2, T1} <= phase_onehot(PH_T1);
                        RUNNING      <= 1'b1;
`ifdef STEP_MODE_EN
                        W            <= resume_beat;
`else
                        W            <= W_B1;
`endif
                    end
                end
                ST_RUN: begin
                    if (div != DIV_LAST) begin
                        div <= div + 1'b1;
                    end else begin
                        div <= '0;
                        case (phase)
                            PH_T1: begin
                                phase        <= PH_T2;
                                {T3, T2, T1} <= phase_onehot(PH_T2);
                            end
                            PH_T2: begin
                                phase        <= PH_T3;
                                {T3, T2, T1} <= phase_onehot(PH_T3);
                            end
                            default: begin
                                if (cycle_end && STOP) begin
                                    state        <= ST_HALT;
                                    phase        <= PH_T1;
                                    W            <= '0;
                                    {T3, T2, T1} <= '0;
                                    RUNNING      <= 1'b0;
`ifdef STEP_MODE_EN
                                    resume_beat  <= W_B1;
                                end else if (STEP) begin
                                    // W keeps the completed beat on display.
                                    state        <= ST_HALT;
                                    phase        <= PH_T1;
                                    {T3, T2, T1} <= '0;
                                    RUNNING      <= 1'b0;
                                    resume_beat  <= beat_next;
`endif
                                end else begin
                                    phase        <= PH_T1;
                                    {T3, T2, T1} <= phase_onehot(PH_T1);
                                    W            <= beat_next;
                                end
                            end
                        endcase
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_beat_timing_gen.sv
// tb_beat_timing_gen: directed bench for beat_timing_gen with T_DIV=1 and
// T_DIV=4 instances. Expected per-CLK output vectors
// {RUNNING,CYC_END,T3,T2,T1,W[2:0]} are queued as stimulus is applied and
// popped against the DUT at each falling edge.
module tb_beat_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr = 1'b1;
    logic qd1 = 1'b0, s1 = 1'b0, l1 = 1'b0, st1 = 1'b0;
    logic qd4 = 1'b0, s4 = 1'b0, l4 = 1'b0, st4 = 1'b0;
    logic t1a, t2a, t3a, run1, ce1;
    logic t1b, t2b, t3b, run4, ce4;
    logic [2:0] w1, w4;
`ifdef STEP_MODE_EN
    logic step1 = 1'b0, step4 = 1'b0;
`endif

    beat_timing_gen #(.T_DIV(1), .QD_SYNC(2)) dut1 (
        .CLK(clk), .CLR(clr), .QD(qd1), .SHORT(s1), .LONG(l1), .STOP(st1),
`ifdef STEP_MODE_EN
        .STEP(step1),
`endif
        .T1(t1a), .T2(t2a), .T3(t3a), .W(w1), .RUNNING(run1), .CYC_END(ce1)
    );

    beat_timing_gen #(.T_DIV(4), .QD_SYNC(2)) dut4 (
        .CLK(clk), .CLR(clr), .QD(qd4), .SHORT(s4), .LONG(l4), .STOP(st4),
`ifdef STEP_MODE_EN
        .STEP(step4),
`endif
        .T1(t1b), .T2(t2b), .T3(t3b), .W(w4), .RUNNING(run4), .CYC_END(ce4)
    );

    logic [7:0] obs1, obs4;
    assign obs1 = {run1, ce1, t3a, t2a, t1a, w1};
    assign obs4 = {run4, ce4, t3b, t2b, t1b, w4};

    logic [7:0] sb[$];
    int tests  = 0;
    int failed = 0;

    task automatic check_pop(input string tag, input int sel);
        logic [7:0] exp, obs;
        exp = sb.pop_front();
        obs = (sel == 4) ? obs4 : obs1;
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b ({RUN,CYC_END,T3,T2,T1,W})", tag, obs, exp);
        end
    endtask

    // Check the head entry now, then one entry per falling edge until empty.
    task automatic drain(input string tag, input int sel);
        check_pop(tag, sel);
        while (sb.size() != 0) begin
            @(negedge clk);
            check_pop(tag, sel);
        end
    endtask

    task automatic hold(input string tag, input int sel, input logic [7:0] val, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sb.push_back(val);
            check_pop(tag, sel);
        end
    endtask

    function automatic void push_beat(input logic [2:0] w, input int tdiv, input bit last);
        for (int ph = 0; ph < 3; ph++)
            for (int d = 0; d < tdiv; d++)
                sb.push_back({1'b1, (last && ph == 2 && d == tdiv - 1), 3'(3'b001 << ph), w});
    endfunction

    task automatic set_in(input int sel, input logic s, input logic l, input logic stp);
        if (sel == 4) begin s4 = s; l4 = l; st4 = stp; end
        else          begin s1 = s; l1 = l; st1 = stp; end
    endtask

    // Raise QD and wait (bounded) for the falling edge showing RUNNING high.
    task automatic wait_run(input string tag, input int sel);
        bit seen;
        seen = 1'b0;
        if (sel == 4) qd4 = 1'b1; else qd1 = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (sel == 4) ? run4 : run1;
        end
        if (sel == 4) qd4 = 1'b0; else qd1 = 1'b0;
        tests++;
        assert (seen) else begin
            failed++;
            $error("FAIL %s: observed RUNNING=0 after 20 CLKs, expected RUNNING=1", tag);
        end
    endtask

    // kind: 0 normal, 1 SHORT, 2 LONG, 3 SHORT+LONG. Entered at the falling
    // edge of the cycle's first CLK; leaves at the next cycle's first CLK.
    task automatic run_cycle(input string tag, input int sel, input int tdiv,
                             input int kind, input bit stp);
        push_beat(3'b001, tdiv, (kind == 1 || kind == 3));
        if (kind == 0 || kind == 2) push_beat(3'b010, tdiv, (kind == 0));
        if (kind == 2) push_beat(3'b100, tdiv, 1'b1);
        check_pop(tag, sel);
        set_in(sel, (kind == 1 || kind == 3), (kind == 2 || kind == 3), stp);
        while (sb.size() != 0) begin
            @(negedge clk);
            check_pop(tag, sel);
        end
        @(negedge clk);
        if (stp) begin
            sb.push_back(8'h00);
            check_pop({tag, "_halt"}, sel);
            set_in(sel, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        // Reset, then idle with QD low.
        repeat (2) @(negedge clk);
        clr = 1'b0;
        hold("reset_idle", 1, 8'h00, 10);
        sb.push_back(8'h00);
        check_pop("reset_idle_div4", 4);

        // T_DIV=1: normal, SHORT (with QD toggled mid-run), SHORT+LONG, LONG+STOP.
        wait_run("start1", 1);
        run_cycle("normal", 1, 1, 0, 1'b0);
        qd1 = 1'b1;
        run_cycle("short_qd_ignored", 1, 1, 1, 1'b0);
        qd1 = 1'b0;
        run_cycle("short_long", 1, 1, 3, 1'b0);
        run_cycle("long_stop", 1, 1, 2, 1'b1);
        hold("halted", 1, 8'h00, 3);
        wait_run("restart1", 1);
        run_cycle("restart_normal_stop", 1, 1, 0, 1'b1);

        // T_DIV=4: full normal cycle, then CLR during W2/T2 with QD held high.
        wait_run("start4", 4);
        run_cycle("div4_normal", 4, 4, 0, 1'b0);
        sb.push_back({1'b1, 1'b0, 3'b001, 3'b001});
        check_pop("div4_next_w1t1", 4);
        repeat (17) @(negedge clk);
        sb.push_back({1'b1, 1'b0, 3'b010, 3'b010});
        check_pop("div4_w2t2", 4);
        qd4 = 1'b1;
        #1 clr = 1'b1;
        #1 sb.push_back(8'h00);
        check_pop("clr_async", 4);
        @(negedge clk);
        clr = 1'b0;
        qd4 = 1'b1;
        hold("qd_held_no_start", 4, 8'h00, 10);
        qd4 = 1'b0;
        hold("qd_low", 4, 8'h00, 3);
        wait_run("restart4", 4);
        run_cycle("div4_short_stop", 4, 4, 1, 1'b1);

`ifdef STEP_MODE_EN
        // Step mode: halt after each beat with W held; STOP forces a fresh W1.
        step1 = 1'b1;
        wait_run("step_start", 1);
        push_beat(3'b001, 1, 1'b0);
        drain("step_w1", 1);
        hold("step_hold_w1", 1, 8'b0000_0001, 2);
        wait_run("step_resume_w2", 1);
        push_beat(3'b010, 1, 1'b1);
        drain("step_w2", 1);
        hold("step_hold_w2", 1, 8'b0000_0010, 2);
        wait_run("step_resume_w1", 1);
        push_beat(3'b001, 1, 1'b0);
        drain("step_w1_again", 1);
        hold("step_hold_w1_again", 1, 8'b0000_0001, 1);
        st1 = 1'b1;
        wait_run("step_resume_w2_stop", 1);
        push_beat(3'b010, 1, 1'b1);
        drain("step_w2_stop", 1);
        hold("step_stop_halt", 1, 8'h00, 2);
        st1 = 1'b0;
        wait_run("step_fresh_w1", 1);
        push_beat(3'b001, 1, 1'b0);
        drain("step_fresh_w1", 1);
        hold("step_hold_fresh", 1, 8'b0000_0001, 1);
        step1 = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
